imem_loader: RTL and testbench

- Instruction memory and program loader directly upstream of the processor core.
- Stores up to 256 8-bit instructions and returns the instruction for the core's `read_address` combinationally, so fetch is same-cycle.
- Accepts a new program as a valid/ready byte stream (from the switches or a host link), then tells the core to restart from address 0.
- While a load is in progress the core sees only a harmless no-op instruction.

---
 rtl/imem_pkg.sv | 18 +
 rtl/imem_array.sv | 29 ++
 rtl/imem_loader.sv | 122 ++++++++++++
 tb/tb_imem_loader.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// Shared definitions for the instruction memory / program loader.
// Holds the loader state encoding, the default no-op instruction and the
// largest supported memory depth.
package imem_pkg;

    // Largest array the 8-bit fetch address can cover.
    localparam int IMEM_DEPTH_MAX = 256;

    // Branch with displacement 0: writes neither a register nor memory.
    localparam logic [7:0] NOP_INSTR_DEFAULT = 8'hC0;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_LOAD    = 2'd1,
        ST_RESTART = 2'd2
    } imem_state_t;

endpackage

// File: rtl/imem_array.sv
// DEPTH x 8 instruction storage: one synchronous write port, one asynchronous read port.
// Latency: writes land on the rising edge; reads are combinational (zero cycles).
// Backpressure: none, a write is accepted on every cycle i_we is high.
//
// Ports: clock; we/waddr/wdat write port; raddr/rdat combinational read port.
// Contents are deliberately not reset.
module imem_array #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic              clock,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [7:0]        wdat,
    input  logic [ADDR_W-1:0] raddr,
    output logic [7:0]        rdat
);

    logic [7:0] r_mem [DEPTH];

    always_ff @(posedge clock) begin
        if (we) begin
            r_mem[waddr] <= wdat;
        end
    end

    assign rdat = r_mem[raddr];

endmodule

// File: rtl/imem_loader.sv
// Instruction memory with a byte-stream program loader feeding the core's fetch.
// Latency: fetch is combinational (same cycle); load_done/cpu_restart follow the final byte by one edge.
// Backpressure: load_ready is high only in LOAD; bytes offered in RUN or RESTART are not taken.
//
// Ports: clock, clear (async active-low); read_address -> instruction (fetch);
//        load_start, load_valid/load_ready, load_data, load_last (program stream);
//        load_done, cpu_restart (completion pulses); prog_length; load_checksum.
// Optional: define IMEM_CHECKSUM_EN to produce a mod-256 sum of the loaded bytes,
//           otherwise load_checksum is tied to zero.
module imem_loader
    import imem_pkg::*;
#(
    parameter int         DEPTH     = 256,
    parameter int         ADDR_W    = 8,
    parameter logic [7:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic              clock,
    input  logic              clear,
    input  logic [ADDR_W-1:0] read_address,
    output logic [7:0]        instruction,
    input  logic              load_start,
    input  logic              load_valid,
    input  logic [7:0]        load_data,
    input  logic              load_last,
    output logic              load_ready,
    output logic              load_done,
    output logic              cpu_restart,
    output logic [ADDR_W:0]   prog_length,
    output logic [7:0]        load_checksum
);

    imem_state_t       r_state;
    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W:0]   r_prog_len;

    logic              w_xfer;
    logic              w_ptr_at_end;
    logic [ADDR_W:0]   w_ptr_inc;
    logic              w_in_range;
    logic [7:0]        w_rd_dat;

    assign w_xfer       = (r_state == ST_LOAD) && load_valid;
    assign w_ptr_at_end = (r_ptr == ADDR_W'(DEPTH - 1));
    // One bit wider than the pointer so a full array reports DEPTH.
    assign w_ptr_inc    = {1'b0, r_ptr} + 1'b1;

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            r_state    <= ST_RUN;
            r_ptr      <= '0;
            r_prog_len <= '0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (load_start) begin
                        r_state    <= ST_LOAD;
                        r_ptr      <= '0;
                        r_prog_len <= '0;
                    end
                end
                ST_LOAD: begin
                    if (load_valid) begin
                        r_ptr      <= w_ptr_inc[ADDR_W-1:0];
                        r_prog_len <= w_ptr_inc;
                        // A full array ends the load even without load_last,
                        // so the pointer can never wrap onto byte 0.
                        if (load_last || w_ptr_at_end) begin
                            r_state <= ST_RESTART;
                        end
                    end
                end
                ST_RESTART: begin
                    r_state <= ST_RUN;
                end
                default: begin
                    r_state <= ST_RUN;
                end
            endcase
        end
    end

    imem_array #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clock (clock),
        .we    (w_xfer),
        .waddr (r_ptr),
        .wdat  (load_data),
        .raddr (read_address),
        .rdat  (w_rd_dat)
    );

    // Stale bytes beyond the current program, and anything while loading,
    // are masked so the core only ever executes a harmless no-op.
    assign w_in_range  = ({1'b0, read_address} < r_prog_len);
    assign instruction = ((r_state == ST_RUN) && w_in_range) ? w_rd_dat : NOP_INSTR;

    assign load_ready  = (r_state == ST_LOAD);
    assign load_done   = (r_state == ST_RESTART);
    assign cpu_restart = (r_state == ST_RESTART);
    assign prog_length = r_prog_len;

`ifdef IMEM_CHECKSUM_EN
    logic [7:0] r_checksum;

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            r_checksum <= '0;
        end else if ((r_state == ST_RUN) && load_start) begin
            r_checksum <= '0;
        end else if (w_xfer) begin
            r_checksum <= r_checksum + load_data;
        end
    end

    assign load_checksum = r_checksum;
`else
    assign load_checksum = 8'h00;
`endif

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

    logic       clock = 1'b0;
    logic       clear = 1'b1;
    logic [7:0] read_address = 8'h00;
    logic       load_start = 1'b0;
    logic       load_valid = 1'b0;
    logic [7:0] load_data = 8'h00;
    logic       load_last = 1'b0;
    wire  [7:0] instruction;
    wire        load_ready;
    wire        load_done;
    wire        cpu_restart;
    wire  [8:0] prog_length;
    wire  [7:0] load_checksum;

    imem_loader dut (
        .clock         (clock),
        .clear         (clear),
        .read_address  (read_address),
        .instruction   (instruction),
        .load_start    (load_start),
        .load_valid    (load_valid),
        .load_data     (load_data),
        .load_last     (load_last),
        .load_ready    (load_ready),
        .load_done     (load_done),
        .cpu_restart   (cpu_restart),
        .prog_length   (prog_length),
        .load_checksum (load_checksum)
    );

    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: what the core should be able to fetch.
    int mem_m [256];
    int len_m = 0;
    int cks_m = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int exp_instr(input int a);
        return (a < len_m) ? mem_m[a] : 8'hC0;
    endfunction

    function automatic int exp_cks();
`ifdef IMEM_CHECKSUM_EN
        return cks_m;
`else
        return 0;
`endif
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Idle RUN state: check status outputs and fetch every address.
    task automatic check_run(input string tag);
        chk({tag, " len"}, 32'(prog_length), len_m);
        chk({tag, " ready"}, 32'(load_ready), 0);
        chk({tag, " done"}, 32'(load_done), 0);
        chk({tag, " restart"}, 32'(cpu_restart), 0);
        chk({tag, " cks"}, 32'(load_checksum), exp_cks());
        for (int a = 0; a < 256; a++) begin
            read_address = 8'(a);
            #1;
            chk({tag, " fetch"}, 32'(instruction), exp_instr(a));
        end
    endtask

    // gap_mode: 0 none, 1 two idle cycles between bytes, 2 random 0..3.
    task automatic do_load(input string tag, input byte unsigned data_q[$],
                           input bit use_last, input int gap_mode, input bit noise);
        int n_req;
        int eff;
        int gaps;
        n_req = data_q.size();
        eff   = (n_req > 256) ? 256 : n_req;
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        cks_m = 0;
        #1;
        chk({tag, " ready in LOAD"}, 32'(load_ready), 1);
        chk({tag, " len cleared"}, 32'(prog_length), 0);
        chk({tag, " cks cleared"}, 32'(load_checksum), 0);
        for (int i = 0; i < eff; i++) begin
            gaps = (gap_mode == 1) ? 2 : (gap_mode == 2) ? int'($urandom_range(0, 3)) : 0;
            for (int g = 0; g < gaps; g++) begin
                load_valid   = 1'b0;
                load_last    = 1'($urandom_range(0, 1));
                load_data    = 8'($urandom);
                load_start   = noise ? 1'($urandom_range(0, 1)) : 1'b0;
                read_address = 8'($urandom);
                #1;
                chk({tag, " gap instr"}, 32'(instruction), 8'hC0);
                chk({tag, " gap ready"}, 32'(load_ready), 1);
                chk({tag, " gap done"}, 32'(load_done), 0);
                step();
            end
            load_valid   = 1'b1;
            load_data    = data_q[i];
            load_last    = use_last && (i == n_req - 1);
            load_start   = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            read_address = 8'($urandom);
            #1;
            chk({tag, " load instr"}, 32'(instruction), 8'hC0);
            chk({tag, " load ready"}, 32'(load_ready), 1);
            chk({tag, " load done"}, 32'(load_done), 0);
            step();
            mem_m[i] = data_q[i];
            cks_m    = (cks_m + data_q[i]) % 256;
            len_m    = i + 1;
            chk({tag, " len progress"}, 32'(prog_length), len_m);
        end
        load_valid = 1'b0;
        load_last  = 1'b0;
        load_start = noise;
        #1;
        chk({tag, " done pulse"}, 32'(load_done), 1);
        chk({tag, " restart pulse"}, 32'(cpu_restart), 1);
        chk({tag, " ready restart"}, 32'(load_ready), 0);
        chk({tag, " instr restart"}, 32'(instruction), 8'hC0);
        chk({tag, " cks restart"}, 32'(load_checksum), exp_cks());
        step();
        load_start = 1'b0;
        check_run(tag);
    endtask

    initial begin
        byte unsigned q[$];
        int n;
        bit ul;

        for (int i = 0; i < 256; i++) mem_m[i] = 0;

        // Reset state
        #1 clear = 1'b0;
        #10;
        read_address = 8'd0;   #1; chk("rst instr 0", 32'(instruction), 8'hC0);
        read_address = 8'd5;   #1; chk("rst instr 5", 32'(instruction), 8'hC0);
        read_address = 8'd255; #1; chk("rst instr 255", 32'(instruction), 8'hC0);
        chk("rst ready", 32'(load_ready), 0);
        chk("rst len", 32'(prog_length), 0);
        chk("rst done", 32'(load_done), 0);
        chk("rst restart", 32'(cpu_restart), 0);
        chk("rst cks", 32'(load_checksum), 0);
        @(negedge clock);
        clear = 1'b1;
        step();

        // Three-byte program, back to back
        q = '{8'h41, 8'h52, 8'hE3};
        do_load("three", q, 1'b1, 0, 1'b0);
        read_address = 8'd0; #1; chk("three a0", 32'(instruction), 8'h41);
        read_address = 8'd1; #1; chk("three a1", 32'(instruction), 8'h52);
        read_address = 8'd2; #1; chk("three a2", 32'(instruction), 8'hE3);
        read_address = 8'd3; #1; chk("three a3", 32'(instruction), 8'hC0);
        chk("three len", 32'(prog_length), 3);
`ifdef IMEM_CHECKSUM_EN
        chk("three cks", 32'(load_checksum), 8'h76);
`endif

        // Same program with idle cycles between bytes
        do_load("gapped", q, 1'b1, 1, 1'b0);
        chk("gapped len", 32'(prog_length), 3);

        // Full array, no load_last: auto restart after byte 255
        q = {};
        for (int i = 0; i < 256; i++) q.push_back(8'(i));
        do_load("full", q, 1'b0, 0, 1'b0);
        chk("full len", 32'(prog_length), 256);
        read_address = 8'hFF; #1; chk("full aFF", 32'(instruction), 8'hFF);

        // Random programs with gaps, stray load_start and stray load_last
        for (int k = 0; k < 6; k++) begin
            n  = (k == 3) ? 260 : int'($urandom_range(1, 40));
            ul = (n < 256) ? 1'b1 : 1'($urandom_range(0, 1));
            q = {};
            for (int i = 0; i < n; i++) q.push_back(8'($urandom));
            do_load("rand", q, ul, 2, 1'b1);
        end

        // Reset in the middle of a load
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            load_valid = 1'b1;
            load_data  = 8'($urandom);
            step();
        end
        load_valid = 1'b0;
        #1 clear = 1'b0;
        #1;
        len_m = 0;
        cks_m = 0;
        chk("midrst len", 32'(prog_length), 0);
        chk("midrst ready", 32'(load_ready), 0);
        chk("midrst done", 32'(load_done), 0);
        chk("midrst restart", 32'(cpu_restart), 0);
        chk("midrst cks", 32'(load_checksum), 0);
        read_address = 8'd0; #1; chk("midrst a0", 32'(instruction), 8'hC0);
        for (int c = 0; c < 3; c++) begin
            step();
            chk("midrst no done", 32'(load_done), 0);
        end
        @(negedge clock);
        clear = 1'b1;
        step();
        check_run("after rst");

        // Recovery load after the interrupted one
        q = {};
        n = int'($urandom_range(1, 20));
        for (int i = 0; i < n; i++) q.push_back(8'($urandom));
        do_load("recover", q, 1'b1, 2, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
